// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between requesters A and B.
// After reset it clears registers 1..NREGS-1 (one per cycle) before accepting requests.
module regfile_write_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_W     = 5,
  parameter int NREGS      = 32,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WIDTH-1:0]  data_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  data_b,
  output logic              gnt_b,
  output logic              init_busy,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [WIDTH-1:0]  WriteData
);

  typedef enum logic {S_INIT, S_RUN} state_e;

  localparam logic [ADDR_W-1:0] FIRST_REG   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_REG    = ADDR_W'(NREGS - 1);
  localparam state_e            RESET_STATE = INIT_CLEAR ? S_INIT : S_RUN;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              last_gnt_q, last_gnt_d;   // 0: A won last, 1: B won last
  logic              win_a, win_b;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= RESET_STATE;
      clr_cnt_q  <= FIRST_REG;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // A contested cycle goes to whichever side did not win most recently.
  assign win_a = req_a && (!req_b || last_gnt_q);
  assign win_b = req_b && (!req_a || !last_gnt_q);

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    last_gnt_d    = last_gnt_q;
    gnt_a         = 1'b0;
    gnt_b         = 1'b0;
    init_busy     = 1'b0;
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;

    if (!Reset) begin
      case (state_q)
        S_INIT: begin
          init_busy     = 1'b1;
          RegWrite      = 1'b1;
          WriteRegister = clr_cnt_q;
          clr_cnt_d     = clr_cnt_q + FIRST_REG;
          if (clr_cnt_q == LAST_REG) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          // A write to r0 is still acknowledged so the requester can move on.
          if (win_a) begin
            gnt_a      = 1'b1;
            last_gnt_d = 1'b0;
            if (addr_a != '0) begin
              RegWrite      = 1'b1;
              WriteRegister = addr_a;
              WriteData     = data_a;
            end
          end else if (win_b) begin
            gnt_b      = 1'b1;
            last_gnt_d = 1'b1;
            if (addr_b != '0) begin
              RegWrite      = 1'b1;
              WriteRegister = addr_b;
              WriteData     = data_b;
            end
          end
        end
        default: state_d = RESET_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vectors, corner sequences and a randomized
// run compared against a cycle-level behavioural model of the arbiter and register file.
module tb_regfile_write_arbiter;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              req_a, req_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [WIDTH-1:0]  data_a, data_b;
  logic              gnt_a, gnt_b, init_busy, RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [WIDTH-1:0]  WriteData;

  always #5 Clk = ~Clk;

  regfile_write_arbiter #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .NREGS(NREGS), .INIT_CLEAR(1'b1)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .gnt_a(gnt_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .gnt_b(gnt_b),
    .init_busy(init_busy), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] rf     [NREGS];   // register file as written by the DUT
  logic [WIDTH-1:0] rf_exp [NREGS];   // register file as the model expects it

  // Model state: clear cycles still to run, next register to clear, A-has-priority flag.
  int busy_left = 0;
  int clear_reg = 1;
  bit a_next    = 1'b1;
  bit mchk      = 1'b1;

  logic              s_ga, s_gb, s_busy, s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [WIDTH-1:0]  s_data;
  logic              e_ga, e_gb, e_busy, e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [WIDTH-1:0]  e_data;

  typedef struct {
    logic              ra;
    logic [ADDR_W-1:0] aa;
    logic [WIDTH-1:0]  da;
    logic              rb;
    logic [ADDR_W-1:0] ab;
    logic [WIDTH-1:0]  db;
    logic              ega;
    logic              egb;
    logic              ewe;
    logic [ADDR_W-1:0] eaddr;
    logic [WIDTH-1:0]  edata;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One clock cycle: sample at the falling edge, compare with the model, advance both.
  task automatic tick();
    logic [WIDTH-1:0] act_data;
    @(negedge Clk);
    s_ga = gnt_a; s_gb = gnt_b; s_busy = init_busy; s_we = RegWrite;
    s_addr = WriteRegister; s_data = WriteData;

    e_ga = 1'b0; e_gb = 1'b0; e_busy = 1'b0; e_we = 1'b0; e_addr = '0; e_data = '0;
    if (!Reset) begin
      if (busy_left > 0) begin
        e_busy = 1'b1; e_we = 1'b1; e_addr = ADDR_W'(clear_reg);
      end else if (req_a && (!req_b || a_next)) begin
        e_ga = 1'b1; e_we = (addr_a != 0); e_addr = addr_a; e_data = e_we ? data_a : '0;
      end else if (req_b) begin
        e_gb = 1'b1; e_we = (addr_b != 0); e_addr = addr_b; e_data = e_we ? data_b : '0;
      end
    end

    if (mchk) begin
      // Data on a dropped r0 write is a don't-care.
      act_data = ((e_ga || e_gb) && !e_we) ? '0 : s_data;
      check("model_outs", {s_ga, s_gb, s_busy, s_we, s_addr, act_data},
                          {e_ga, e_gb, e_busy, e_we, e_addr, e_data});
    end

    if (s_we === 1'b1 && !$isunknown(s_addr)) rf[s_addr] = s_data;

    if (Reset) begin
      busy_left = NREGS - 1; clear_reg = 1; a_next = 1'b1;
    end else if (busy_left > 0) begin
      rf_exp[clear_reg] = '0; busy_left--; clear_reg++;
    end else if (e_ga) begin
      if (e_we) rf_exp[addr_a] = data_a;
      a_next = 1'b0;
    end else if (e_gb) begin
      if (e_we) rf_exp[addr_b] = data_b;
      a_next = 1'b1;
    end

    @(posedge Clk);
    #1;
  endtask

  initial begin
    bit pa, pb;
    int k;
    logic [WIDTH-1:0] act_d;

    for (int i = 0; i < NREGS; i++) begin
      rf[i]     = (i == 0) ? '0 : (32'hA5A5_0000 | i);
      rf_exp[i] = rf[i];
    end

    vecs[0]  = '{1'b1, 5'd3, 32'd111, 1'b1, 5'd4, 32'd222, 1'b1, 1'b0, 1'b1, 5'd3, 32'd111};
    vecs[1]  = '{1'b0, 5'd3, 32'd111, 1'b1, 5'd4, 32'd222, 1'b0, 1'b1, 1'b1, 5'd4, 32'd222};
    vecs[2]  = '{1'b1, 5'd3, 32'd111, 1'b1, 5'd4, 32'd222, 1'b1, 1'b0, 1'b1, 5'd3, 32'd111};
    vecs[3]  = '{1'b0, 5'd3, 32'd111, 1'b1, 5'd4, 32'd222, 1'b0, 1'b1, 1'b1, 5'd4, 32'd222};
    vecs[4]  = '{1'b1, 5'd5, 32'd42,  1'b0, 5'd0, 32'd0,   1'b1, 1'b0, 1'b1, 5'd5, 32'd42};
    vecs[5]  = '{1'b0, 5'd5, 32'd42,  1'b0, 5'd0, 32'd0,   1'b0, 1'b0, 1'b0, 5'd0, 32'd0};
    vecs[6]  = '{1'b0, 5'd0, 32'd0,   1'b1, 5'd0, 32'd299, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0};
    vecs[7]  = '{1'b1, 5'd9, 32'd15,  1'b1, 5'd9, 32'd145, 1'b1, 1'b0, 1'b1, 5'd9, 32'd15};
    vecs[8]  = '{1'b0, 5'd9, 32'd15,  1'b1, 5'd9, 32'd145, 1'b0, 1'b1, 1'b1, 5'd9, 32'd145};
    vecs[9]  = '{1'b1, 5'd0, 32'd555, 1'b0, 5'd9, 32'd145, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0};
    vecs[10] = '{1'b1, 5'd7, 32'd1,   1'b1, 5'd8, 32'd2,   1'b0, 1'b1, 1'b1, 5'd8, 32'd2};
    vecs[11] = '{1'b1, 5'd7, 32'd1,   1'b0, 5'd8, 32'd2,   1'b1, 1'b0, 1'b1, 5'd7, 32'd1};

    // Reset for two cycles with A requesting: everything must stay quiet.
    Reset = 1'b1;
    req_a = 1'b1; addr_a = 5'd6; data_a = 32'd7;
    req_b = 1'b0; addr_b = '0;   data_b = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset_outs", {s_ga, s_gb, s_busy, s_we, s_addr, s_data}, 64'd0);
    end

    // Clear sequence while idle: registers 1..31 in order, 31 cycles.
    Reset = 1'b0; req_a = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      tick();
      check($sformatf("clear_%0d", i), {s_busy, s_we, s_addr, s_data},
            {1'b1, 1'b1, ADDR_W'(i), {WIDTH{1'b0}}});
    end
    tick();
    check("init_done", {s_busy, s_we}, 2'b00);
    check("reg17_cleared", rf[17], 64'd0);

    // Directed vectors in RUN.
    for (int i = 0; i < 12; i++) begin
      req_a = vecs[i].ra; addr_a = vecs[i].aa; data_a = vecs[i].da;
      req_b = vecs[i].rb; addr_b = vecs[i].ab; data_b = vecs[i].db;
      tick();
      act_d = ((vecs[i].ega || vecs[i].egb) && !vecs[i].ewe) ? '0 : s_data;
      check($sformatf("vec%0d", i), {s_ga, s_gb, s_we, s_addr, act_d},
            {vecs[i].ega, vecs[i].egb, vecs[i].ewe, vecs[i].eaddr, vecs[i].edata});
    end
    req_a = 1'b0; req_b = 1'b0;
    check("reg3", rf[3], 64'd111);
    check("reg4", rf[4], 64'd222);
    check("reg5", rf[5], 64'd42);
    check("reg0", rf[0], 64'd0);
    check("reg9_last_writer", rf[9], 64'd145);
    check("reg7", rf[7], 64'd1);
    check("reg8", rf[8], 64'd2);

    // Randomized traffic honouring the hold-until-granted handshake, with rare resets.
    pa = 1'b0; pb = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!pa && $urandom_range(0, 2) != 0) begin
        pa = 1'b1; addr_a = ADDR_W'($urandom_range(0, NREGS - 1)); data_a = $urandom;
      end
      if (!pb && $urandom_range(0, 2) != 0) begin
        pb = 1'b1; addr_b = ADDR_W'($urandom_range(0, NREGS - 1)); data_b = $urandom;
      end
      req_a = pa; req_b = pb;
      Reset = ($urandom_range(0, 149) == 0);
      tick();
      if (e_ga) pa = 1'b0;
      if (e_gb) pb = 1'b0;
    end
    Reset = 1'b0; req_a = 1'b0; req_b = 1'b0;
    while (busy_left > 0) tick();
    for (int i = 0; i < NREGS; i++) check($sformatf("rf%0d", i), rf[i], rf_exp[i]);

    // Reset in the middle of the clear sequence with A requesting throughout.
    Reset = 1'b1; req_a = 1'b1; addr_a = 5'd12; data_a = 32'd77;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_clear_addr", s_addr, 64'd10);
    Reset = 1'b1;
    tick();
    check("mid_reset_quiet", {s_ga, s_busy, s_we}, 3'b000);
    Reset = 1'b0;
    k = 0;
    while (k < 40) begin
      tick();
      if (k == 0) check("restart_addr", s_addr, 64'd1);
      if (s_ga === 1'b1) break;
      k++;
    end
    check("gnt_after_restart_cycles", k, 64'd31);
    req_a = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
